// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer fill engine:
// pattern modes, FSM states, the RGB332 bar palette and elaboration helpers.
package fb_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID   = 3'd0,
    MODE_VBARS   = 3'd1,
    MODE_HBARS   = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_ADDR    = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam int unsigned BAR_W = 3;

  localparam logic [7:0] PALETTE [8] = '{
    8'hE0, 8'h1C, 8'h03, 8'hFF, 8'hFC, 8'h1F, 8'hE3, 8'h00
  };

  // Counter width for 0..value-1, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  // Position of bar boundary j; unused slots get an unreachable value.
  function automatic int unsigned bar_bound(input int unsigned j,
                                            input int unsigned total,
                                            input int unsigned bars);
    if (j + 1 < bars) return ((j + 1) * total) / bars;
    return 32'hFFFF_FFFF;
  endfunction

endpackage

// File: rtl/fb_xy_scan.sv
// Raster position tracker: x/y counters, per-axis bar indices and the
// last-pixel flag, plus the values those take after the pending update.
module fb_xy_scan
  import fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 400,
  parameter int unsigned NUM_BARS = 3
) (
  input  logic                          pclk,
  input  logic                          reset_n,
  input  logic                          advance,
  input  logic                          clear,
  output logic [clog2(H_ACTIVE)-1:0]    x_nxt,
  output logic [clog2(V_ACTIVE)-1:0]    y_nxt,
  output logic [BAR_W-1:0]              xbar_nxt,
  output logic [BAR_W-1:0]              ybar_nxt,
  output logic                          last
);

  localparam int unsigned XW = clog2(H_ACTIVE);
  localparam int unsigned YW = clog2(V_ACTIVE);

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [BAR_W-1:0] xbar, ybar;
  logic [XW:0]      x_inc;
  logic [YW:0]      y_inc;
  logic             x_end, y_end;
  logic [XW:0]      xb_bound [8];
  logic [YW:0]      yb_bound [8];

  for (genvar j = 0; j < 8; j++) begin : g_bound
    assign xb_bound[j] = (XW+1)'(bar_bound(j, H_ACTIVE, NUM_BARS));
    assign yb_bound[j] = (YW+1)'(bar_bound(j, V_ACTIVE, NUM_BARS));
  end

  assign x_inc = {1'b0, x} + (XW+1)'(1);
  assign y_inc = {1'b0, y} + (YW+1)'(1);
  assign x_end = (x == XW'(H_ACTIVE - 1));
  assign y_end = (y == YW'(V_ACTIVE - 1));
  assign last  = x_end && y_end;

  // Bar index steps when the incremented coordinate lands on the next boundary.
  always_comb begin
    x_nxt    = x;
    y_nxt    = y;
    xbar_nxt = xbar;
    ybar_nxt = ybar;
    if (clear) begin
      x_nxt    = '0;
      y_nxt    = '0;
      xbar_nxt = '0;
      ybar_nxt = '0;
    end else if (advance) begin
      if (x_end) begin
        x_nxt    = '0;
        xbar_nxt = '0;
        if (y_end) begin
          y_nxt    = '0;
          ybar_nxt = '0;
        end else begin
          y_nxt = y_inc[YW-1:0];
          if (y_inc == yb_bound[ybar]) ybar_nxt = ybar + BAR_W'(1);
        end
      end else begin
        x_nxt = x_inc[XW-1:0];
        if (x_inc == xb_bound[xbar]) xbar_nxt = xbar + BAR_W'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      xbar <= '0;
      ybar <= '0;
    end else begin
      x    <= x_nxt;
      y    <= y_nxt;
      xbar <= xbar_nxt;
      ybar <= ybar_nxt;
    end
  end

endmodule

// File: rtl/fb_pattern_fill.sv
// Framebuffer fill engine: on start, streams one H_ACTIVE x V_ACTIVE test
// pattern into the framebuffer write port with ready/valid backpressure.
module fb_pattern_fill
  import fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 400,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_BARS    = 3,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] color0,
  input  logic [DATA_W-1:0] color1,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = clog2(H_ACTIVE);
  localparam int unsigned YW = clog2(V_ACTIVE);

  state_t            state, state_nxt;
  logic [2:0]        mode_q;
  logic [DATA_W-1:0] color0_q, color1_q;
  logic              load, xfer, last;
  logic [XW-1:0]     x_nxt, xs;
  logic [YW-1:0]     y_nxt, ys;
  logic [BAR_W-1:0]  xbar_nxt, ybar_nxt;
  logic [2:0]        sel_mode;
  logic [DATA_W-1:0] sel_c0, sel_c1, pix_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  assign load = (state == ST_IDLE) && start;
  assign xfer = (state == ST_FILL) && wr_ready;

  fb_xy_scan #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .NUM_BARS (NUM_BARS)
  ) u_scan (
    .pclk     (pclk),
    .reset_n  (reset_n),
    .advance  (xfer),
    .clear    (load),
    .x_nxt    (x_nxt),
    .y_nxt    (y_nxt),
    .xbar_nxt (xbar_nxt),
    .ybar_nxt (ybar_nxt),
    .last     (last)
  );

  // Pixel for the beat after this edge; on load the live inputs stand in for
  // the not-yet-latched copies so pixel (0,0) is registered with everything else.
  always_comb begin
    sel_mode = load ? mode   : mode_q;
    sel_c0   = load ? color0 : color0_q;
    sel_c1   = load ? color1 : color1_q;
    addr_nxt = load ? fb_base : wr_addr + ADDR_W'(1);
    xs       = x_nxt >> CHECK_SHIFT;
    ys       = y_nxt >> CHECK_SHIFT;
    pix_nxt  = sel_c0;
    case (sel_mode)
      MODE_VBARS:   pix_nxt = DATA_W'(PALETTE[xbar_nxt]);
      MODE_HBARS:   pix_nxt = DATA_W'(PALETTE[ybar_nxt]);
      MODE_CHECKER: pix_nxt = (xs[0] ^ ys[0]) ? sel_c1 : sel_c0;
      MODE_ADDR:    pix_nxt = DATA_W'(addr_nxt);
      default:      pix_nxt = sel_c0;
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_FILL;
      ST_FILL: begin
        if (abort)                  state_nxt = ST_IDLE;
        else if (wr_ready && last)  state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en = (state == ST_FILL);
    busy  = (state == ST_FILL);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= '0;
      color0_q <= '0;
      color1_q <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (load) begin
        mode_q   <= mode;
        color0_q <= color0;
        color1_q <= color1;
      end
      if (load || xfer) begin
        wr_addr <= addr_nxt;
        wr_data <= pix_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fb_pattern_fill.sv
// Directed bench for fb_pattern_fill on an 8x4 frame with 3 bars and 2-pixel
// checker squares; expected values are hand-derived constants.
module tb_fb_pattern_fill;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  color0 = 8'h00;
  logic [7:0]  color1 = 8'h00;
  logic [31:0] fb_base = 32'h0;
  logic        wr_ready = 1'b1;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_addr [$];
  logic [7:0]  cap_data [$];
  int done_cnt, done_cycle, last_xfer, stall_bad;

  fb_pattern_fill #(
    .H_ACTIVE    (8),
    .V_ACTIVE    (4),
    .ADDR_W      (32),
    .DATA_W      (8),
    .NUM_BARS    (3),
    .CHECK_SHIFT (1)
  ) dut (
    .pclk     (pclk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .color0   (color0),
    .color1   (color1),
    .fb_base  (fb_base),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [2:0] m, input logic [7:0] c0, input logic [7:0] c1,
                      input logic [31:0] base);
    @(negedge pclk);
    mode = m; color0 = c0; color1 = c1; fb_base = base;
    start = 1'b1;
  endtask

  // Clears start, drives wr_ready, records every accepted beat until done.
  task automatic run_fill(input bit throttle);
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [7:0]  prev_data;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    cap_addr.delete(); cap_data.delete();
    done_cnt = 0; done_cycle = -1; last_xfer = -1; stall_bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge pclk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        done_cycle = c;
        break;
      end
      if (prev_stall && (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data))
        stall_bad++;
      wr_ready   = throttle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (wr_en && wr_ready) begin
        cap_addr.push_back(wr_addr);
        cap_data.push_back(wr_data);
        last_xfer = c;
      end
    end
    wr_ready = 1'b1;
  endtask

  task automatic finish_checks(input string tag);
    check({tag, " count"}, 64'(cap_addr.size()), 64'd32);
    check({tag, " done seen"}, 64'(done_cnt), 64'd1);
    check({tag, " done timing"}, 64'(done_cycle), 64'(last_xfer + 1));
    @(negedge pclk);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    check({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  function automatic int addr_bad(input logic [31:0] base);
    int bad = 0;
    for (int i = 0; i < cap_addr.size(); i++)
      if (cap_addr[i] !== base + 32'(i)) bad++;
    return bad;
  endfunction

  function automatic int data_bad_const(input logic [7:0] value);
    int bad = 0;
    for (int i = 0; i < cap_data.size(); i++)
      if (cap_data[i] !== value) bad++;
    return bad;
  endfunction

  initial begin
    logic [7:0]  vbar_row [8];
    logic [7:0]  hbar_col [4];
    logic [63:0] row;
    logic [31:0] quad;
    int          bad;

    vbar_row = '{8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'h1C, 8'h03, 8'h03, 8'h03};
    hbar_col = '{8'hE0, 8'h1C, 8'h03, 8'h03};

    #1 reset_n = 1'b0;
    repeat (2) @(negedge pclk);
    check("reset wr_en", 64'(wr_en), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset wr_addr", 64'(wr_addr), 64'd0);
    check("reset wr_data", 64'(wr_data), 64'd0);
    reset_n = 1'b1;

    // SOLID
    kick(3'd0, 8'h5A, 8'h00, 32'h100);
    run_fill(1'b0);
    check("solid first addr", 64'(cap_addr[0]), 64'h100);
    check("solid last addr", 64'(cap_addr[31]), 64'h11F);
    check("solid addr seq", 64'(addr_bad(32'h100)), 64'd0);
    check("solid data", 64'(data_bad_const(8'h5A)), 64'd0);
    finish_checks("solid");

    // VBARS: boundaries at x=2 and x=5
    kick(3'd1, 8'h00, 8'h00, 32'h0);
    run_fill(1'b0);
    check("vbars x1", 64'(cap_data[1]), 64'hE0);
    check("vbars x2", 64'(cap_data[2]), 64'h1C);
    check("vbars x4", 64'(cap_data[4]), 64'h1C);
    check("vbars x5", 64'(cap_data[5]), 64'h03);
    check("vbars x7", 64'(cap_data[7]), 64'h03);
    bad = 0;
    for (int i = 0; i < cap_data.size(); i++) if (cap_data[i] !== vbar_row[i % 8]) bad++;
    check("vbars frame", 64'(bad), 64'd0);
    finish_checks("vbars");

    // HBARS: boundaries at y=1 and y=2
    kick(3'd2, 8'h00, 8'h00, 32'h0);
    run_fill(1'b0);
    bad = 0;
    for (int i = 0; i < cap_data.size(); i++) if (cap_data[i] !== hbar_col[i / 8]) bad++;
    check("hbars frame", 64'(bad), 64'd0);
    check("hbars y1", 64'(cap_data[8]), 64'h1C);
    finish_checks("hbars");

    // CHECKER with 2-pixel squares
    kick(3'd3, 8'h00, 8'hFF, 32'h40);
    run_fill(1'b0);
    row = '0;
    for (int i = 0; i < 8; i++) row = {row[55:0], cap_data[i]};
    check("checker row0", row, 64'h0000FFFF0000FFFF);
    row = '0;
    for (int i = 16; i < 24; i++) row = {row[55:0], cap_data[i]};
    check("checker row2", row, 64'hFFFF0000FFFF0000);
    finish_checks("checker");

    // Backpressure, wr_ready 1,0,0,1
    kick(3'd0, 8'hC3, 8'h00, 32'h800);
    run_fill(1'b1);
    check("bp stable", 64'(stall_bad), 64'd0);
    check("bp addr seq", 64'(addr_bad(32'h800)), 64'd0);
    check("bp data", 64'(data_bad_const(8'hC3)), 64'd0);
    finish_checks("bp");

    // ADDR ramp across the 32-bit wrap
    kick(3'd4, 8'h00, 8'h00, 32'hFFFF_FFFE);
    run_fill(1'b0);
    check("addr wrap hi", 64'(cap_addr[1]), 64'hFFFF_FFFF);
    check("addr wrap lo", 64'(cap_addr[2]), 64'h0);
    check("addr last", 64'(cap_addr[31]), 64'h1D);
    quad = {cap_data[0], cap_data[1], cap_data[2], cap_data[3]};
    check("addr ramp", 64'(quad), 64'hFEFF0001);
    check("addr seq", 64'(addr_bad(32'hFFFF_FFFE)), 64'd0);
    finish_checks("addr");

    // Reserved mode falls back to colour 0
    kick(3'd6, 8'h77, 8'h88, 32'h0);
    run_fill(1'b0);
    check("reserved data", 64'(data_bad_const(8'h77)), 64'd0);
    finish_checks("reserved");

    // Ignored start during FILL, then abort with a transfer on the same edge
    kick(3'd0, 8'h11, 8'h22, 32'h200);
    @(negedge pclk);
    start = 1'b0;
    repeat (3) @(negedge pclk);
    check("fill addr before restart", 64'(wr_addr), 64'h203);
    start = 1'b1; fb_base = 32'h400; mode = 3'd4;
    @(negedge pclk);
    start = 1'b0;
    check("start in fill addr", 64'(wr_addr), 64'h204);
    check("start in fill data", 64'(wr_data), 64'h11);
    check("start in fill busy", 64'(busy), 64'd1);
    repeat (5) @(negedge pclk);
    check("pre-abort addr", 64'(wr_addr), 64'h209);
    abort = 1'b1;
    @(negedge pclk);
    abort = 1'b0;
    check("abort wr_en", 64'(wr_en), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort addr", 64'(wr_addr), 64'h20A);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || wr_en) bad++;
      @(negedge pclk);
    end
    check("abort no done", 64'(bad), 64'd0);

    // Asynchronous reset mid-fill
    kick(3'd0, 8'h33, 8'h00, 32'h300);
    @(negedge pclk);
    start = 1'b0;
    repeat (4) @(negedge pclk);
    #2 reset_n = 1'b0;
    #1;
    check("areset wr_en", 64'(wr_en), 64'd0);
    check("areset busy", 64'(busy), 64'd0);
    check("areset done", 64'(done), 64'd0);
    check("areset addr", 64'(wr_addr), 64'd0);
    check("areset data", 64'(wr_data), 64'd0);
    @(negedge pclk);
    reset_n = 1'b1;

    kick(3'd0, 8'h33, 8'h00, 32'h300);
    run_fill(1'b0);
    check("restart first addr", 64'(cap_addr[0]), 64'h300);
    check("restart addr seq", 64'(addr_bad(32'h300)), 64'd0);
    check("restart data", 64'(data_bad_const(8'h33)), 64'd0);
    finish_checks("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_pattern_fill.md
Name: fb_pattern_fill

Overview:
- Parametrised framebuffer fill engine; writes a full H_ACTIVE x V_ACTIVE test pattern into the VGA framebuffer through its CPU-side write port (cpu_wr/cpu_addr/cpu_data).
- Successor to the hard-wired colour-bar writer in the top level:
  - runs on demand (start/busy/done handshake);
  - derives x/y from its own counters, not the display timing;
  - supports several pattern modes, honours write backpressure, and can be aborted.
- Sits between top-level control and the vga block; runs in the pclk domain.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 400, lines per frame.
- ADDR_W, 32, framebuffer address width.
- DATA_W, 8, pixel width (RGB332 at default).
- NUM_BARS, 3, bar count for bar modes; legal range 1..8.
- CHECK_SHIFT, 5, checker square size = 2**CHECK_SHIFT pixels.

Ports:
- pclk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fill; sampled in IDLE only.
- abort  in  1  stop fill; honoured in FILL only.
- mode  in  3  pattern select; latched at start.
- color0  in  DATA_W  primary colour; latched at start.
- color1  in  DATA_W  secondary colour; latched at start.
- fb_base  in  ADDR_W  first pixel address; latched at start.
- wr_ready  in  1  sink accepts the current beat.
- wr_en  out  1  write valid.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  pixel value.
- busy  out  1  high in FILL.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset: one clock (pclk); reset is asynchronous and active-low (reset_n).
  - Reset_n low forces state IDLE and clears wr_en, busy, done, wr_addr, wr_data, x, y and all latched inputs to 0.
  - Reset asserted mid-fill aborts the fill immediately; no done pulse.
- FSM states: IDLE, FILL, DONE.
- IDLE, start=1:
  - latch mode, color0, color1, fb_base;
  - x=0, y=0, wr_addr=fb_base;
  - go to FILL.
  - The first beat (pixel 0,0) is presented on the next cycle: wr_en=1, busy=1.
- Beat transfer: wr_en && wr_ready on a rising edge.
  - While wr_ready=0, wr_en, wr_addr and wr_data are held stable.
  - No combinational path from wr_ready to any output.
- On each transfer:
  - wr_addr increments by 1, modulo 2**ADDR_W (wraps silently);
  - x increments; at x=H_ACTIVE-1, x goes to 0 and y increments;
  - the next wr_data is registered, so throughput is one pixel per cycle under continuous wr_ready.
- Last transfer (x=H_ACTIVE-1, y=V_ACTIVE-1):
  - go to DONE; wr_en=0, busy=0, done=1 for exactly one cycle;
  - then IDLE.
  - Total transfers = H_ACTIVE*V_ACTIVE exactly.
- start during FILL or DONE is ignored. start held high in IDLE after DONE begins a new fill.
- abort=1 in FILL:
  - next cycle wr_en=0, busy=0, state IDLE; no done pulse.
  - abort and a transfer on the same edge: the transfer counts, then abort takes effect.
- abort in IDLE/DONE has no effect.
- Pattern (from latched values and current x,y):
  - 0 SOLID: color0.
  - 1 VBARS: PALETTE[k], where k = number of boundaries B_j <= x, with B_j = floor((j+1)*H_ACTIVE/NUM_BARS), j = 0..NUM_BARS-2, all elaboration constants.
    - Implement with a bar counter that increments when x reaches the next boundary and resets at line start. No runtime divider.
  - 2 HBARS: same rule applied to y with V_ACTIVE.
  - 3 CHECKER: ((x>>CHECK_SHIFT) ^ (y>>CHECK_SHIFT)) & 1 selects color1, else color0.
  - 4 ADDR: wr_addr[DATA_W-1:0], i.e. a ramp.
  - 5..7 reserved: behave as SOLID.
- PALETTE entries 0..7 (RGB332): 0xE0 red, 0x1C green, 0x03 blue, 0xFF white, 0xFC yellow, 0x1F cyan, 0xE3 magenta, 0x00 black.
- x, y counters are sized clog2(H_ACTIVE), clog2(V_ACTIVE).

Decomposition:
- Shared package fb_pkg:
  - mode enum (MODE_SOLID..MODE_ADDR);
  - FSM state typedef;
  - 8-entry RGB332 PALETTE constant;
  - clog2 helper function.
- One sub-module: fb_xy_scan. It owns the x/y counters, bar counters and the last-pixel flag, with advance and clear inputs. The top module keeps the FSM, latching and pattern mux.

Test Plan:
- SOLID, H_ACTIVE=8, V_ACTIVE=4, fb_base=0x100, color0=0x5A, wr_ready=1:
  - 32 writes, addresses 0x100..0x11F, all 0x5A;
  - done pulses once, the cycle after write 0x11F; busy low afterwards.
- VBARS, defaults:
  - on line 0: pixel x=212 -> 0xE0, x=213 -> 0x1C, x=425 -> 0x1C, x=426 -> 0x03, x=639 -> 0x03;
  - 256000 writes total.
- CHECKER, 8x4, CHECK_SHIFT=1, color0=0x00, color1=0xFF:
  - row 0 = 00,00,FF,FF,00,00,FF,FF; row 2 is the inverse.
- Backpressure, SOLID 8x4, wr_ready toggling 1,0,0,1 repeating:
  - outputs stable while wr_ready=0;
  - exactly 32 transfers; no address skipped or duplicated.
- ADDR mode, fb_base=0xFFFFFFFE, 8x4:
  - wr_addr wraps 0xFFFFFFFF -> 0x00000000;
  - wr_data = FE, FF, 00, 01, ...
- Abort after 10 transfers:
  - wr_en low next cycle, no done pulse;
  - start pulse during FILL ignored;
  - reset_n pulled low mid-fill clears all outputs asynchronously;
  - a subsequent start restarts from fb_base.
